// File: rtl/create_mlp_activations.sv
// create_mlp_activations: reads the 7x7 timestamp/polarity patch around one DVS event, streams age and
// polarity activations two pixels per beat, then writes the event back. Optional: MLP_CENTER_MASK_EN.
module create_mlp_activations #(
  parameter int DVS_WIDTH       = 346,
  parameter int DVS_HEIGHT      = 260,
  parameter int WORD_SIZE       = 18,
  parameter int CAVIAR_X_Y_BITS = 9,
  parameter int TIMESTAMP_BITS  = 16,
  parameter int POLARITY_BITS   = 2,
  parameter int PATCH_RADIUS    = 3,
  parameter int TAU             = 1000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           read_data_mem_vld1,
  input  logic                           read_data_mem_vld2,
  input  logic [WORD_SIZE-1:0]           read_data1_mem,
  input  logic [WORD_SIZE-1:0]           read_data2_mem,
  output logic [WORD_SIZE-1:0]           write_data_mem,
  output logic                           rw,
  output logic                           cen,
  output logic [CAVIAR_X_Y_BITS-1:0]     addr_port1_x,
  output logic [CAVIAR_X_Y_BITS-1:0]     addr_port1_y,
  output logic [CAVIAR_X_Y_BITS-1:0]     addr_port2_x,
  output logic [CAVIAR_X_Y_BITS-1:0]     addr_port2_y,
  input  logic [2*CAVIAR_X_Y_BITS:0]     cavier_in,
  input  logic                           cavier_in_vld,
  input  logic [TIMESTAMP_BITS-1:0]      current_timestamp,
  input  logic                           current_timestamp_vld,
  output logic [TIMESTAMP_BITS-1:0]      MLPout1,
  output logic [POLARITY_BITS-1:0]       MLPout2,
  output logic [TIMESTAMP_BITS-1:0]      MLPout3,
  output logic [POLARITY_BITS-1:0]       MLPout4,
  output logic                           MLPvld,
  output logic                           done,
  output logic [2:0]                     dbg_state
);
  localparam int CXY    = CAVIAR_X_Y_BITS;
  localparam int TS     = TIMESTAMP_BITS;
  localparam int PB     = POLARITY_BITS;
  localparam int AW     = TS + PB;
  localparam int PSIDE  = 2 * PATCH_RADIUS + 1;
  localparam int NPIX   = PSIDE * PSIDE;
  localparam int NBEATS = (NPIX + 1) / 2;
  localparam int IW     = $clog2(NBEATS + 1);
  localparam int KW     = IW + 1;
  localparam int CW     = CXY + 2;
  localparam logic [PB-1:0] POL_ON  = PB'(1);
  localparam logic [PB-1:0] POL_OFF = '1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE, S_DONE} state_t;

  typedef struct packed {
    logic           oob;
    logic [CXY-1:0] ax;
    logic [CXY-1:0] ay;
  } pix_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CXY-1:0] x_q, x_d, y_q, y_d;
  logic           pol_q, pol_d;
  logic [TS-1:0]  ts_q, ts_d;
  logic           pend_q, pend_d;
  logic           zero1_q, zero1_d, zero2_q, zero2_d;
  logic [AW-1:0]  act1_q, act1_d, act2_q, act2_d;
  logic           mlpvld_q, mlpvld_d;
  logic           accept;
  pix_t           p1, p2;

  // Pixel k of the patch around (cx,cy); out-of-sensor pixels and the padding slot k>=NPIX read address 0.
  function automatic pix_t map_pix(input logic [KW-1:0] k, input logic [CXY-1:0] cx,
                                   input logic [CXY-1:0] cy);
    logic [KW-1:0]        row, col;
    logic signed [CW-1:0] px, py;
    pix_t                 p;
    row   = k / KW'(PSIDE);
    col   = k % KW'(PSIDE);
    px    = $signed({{(CW-KW){1'b0}}, col}) + $signed({2'b00, cx}) - $signed(CW'(PATCH_RADIUS));
    py    = $signed({{(CW-KW){1'b0}}, row}) + $signed({2'b00, cy}) - $signed(CW'(PATCH_RADIUS));
    p.oob = (k >= KW'(NPIX)) || (px < 0) || (py < 0) ||
            (px >= $signed(CW'(DVS_WIDTH))) || (py >= $signed(CW'(DVS_HEIGHT)));
    p.ax  = p.oob ? '0 : px[CXY-1:0];
    p.ay  = p.oob ? '0 : py[CXY-1:0];
    return p;
  endfunction

  // Codes with bit0 set (ON/OFF) carry a timestamp; subtraction wraps so old-vs-new stays correct.
  function automatic logic [AW-1:0] activate(input logic [WORD_SIZE-1:0] w, input logic [TS-1:0] cur,
                                             input logic zero);
    logic [TS-1:0] delta;
    logic [AW-1:0] a;
    delta = cur - w[WORD_SIZE-1:PB];
    a     = '0;
    if (!zero && w[0] && (delta < TS'(TAU))) a = {TS'(TAU) - delta, w[PB-1:0]};
    return a;
  endfunction

  // An event is taken on any IDLE cycle with both valids high; there is no ready, so events
  // presented while busy are dropped rather than back-pressured.
  assign accept = cavier_in_vld && current_timestamp_vld;

  always_comb begin
    p1 = map_pix({idx_q, 1'b0}, x_q, y_q);
    p2 = map_pix({idx_q, 1'b1}, x_q, y_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      pol_q    <= 1'b0;
      ts_q     <= '0;
      pend_q   <= 1'b0;
      zero1_q  <= 1'b0;
      zero2_q  <= 1'b0;
      act1_q   <= '0;
      act2_q   <= '0;
      mlpvld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pol_q    <= pol_d;
      ts_q     <= ts_d;
      pend_q   <= pend_d;
      zero1_q  <= zero1_d;
      zero2_q  <= zero2_d;
      act1_q   <= act1_d;
      act2_q   <= act2_d;
      mlpvld_q <= mlpvld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_READ;
      S_READ:  if (idx_q == IW'(NBEATS - 1)) state_d = S_DRAIN;
      S_DRAIN: state_d = S_WRITE;  // last beat's data is captured on this edge
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    x_d   = x_q;
    y_d   = y_q;
    pol_d = pol_q;
    ts_d  = ts_q;
    if (state_q == S_IDLE) begin
      idx_d = '0;
      if (accept) begin
        x_d   = cavier_in[2*CXY:CXY+1];
        y_d   = cavier_in[CXY:1];
        pol_d = cavier_in[0];
        ts_d  = current_timestamp;
      end
    end else if (state_q == S_READ) begin
      idx_d = idx_q + 1'b1;
    end
    pend_d  = (state_q == S_READ);
    zero1_d = p1.oob;
    zero2_d = p2.oob;
`ifdef MLP_CENTER_MASK_EN
    if (idx_q == IW'(NPIX / 4)) zero1_d = 1'b1;
`endif
    mlpvld_d = pend_q;
    act1_d   = act1_q;
    act2_d   = act2_q;
    if (pend_q) begin
      act1_d = activate(read_data1_mem, ts_q, zero1_q || !read_data_mem_vld1);
      act2_d = activate(read_data2_mem, ts_q, zero2_q || !read_data_mem_vld2);
    end
  end

  always_comb begin
    cen            = 1'b0;
    rw             = 1'b0;
    done           = 1'b0;
    addr_port1_x   = '0;
    addr_port1_y   = '0;
    addr_port2_x   = '0;
    addr_port2_y   = '0;
    write_data_mem = '0;
    unique case (state_q)
      S_READ: begin
        cen          = 1'b1;
        addr_port1_x = p1.ax;
        addr_port1_y = p1.ay;
        addr_port2_x = p2.ax;
        addr_port2_y = p2.ay;
      end
      S_WRITE: begin
        cen            = 1'b1;
        rw             = 1'b1;
        addr_port1_x   = x_q;
        addr_port1_y   = y_q;
        write_data_mem = {ts_q, pol_q ? POL_ON : POL_OFF};
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign MLPout1   = act1_q[AW-1:PB];
  assign MLPout2   = act1_q[PB-1:0];
  assign MLPout3   = act2_q[AW-1:PB];
  assign MLPout4   = act2_q[PB-1:0];
  assign MLPvld    = mlpvld_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_create_mlp_activations.sv
// Bench for create_mlp_activations: patch memory model, event driver, queue scoreboard and summary.
module tb_create_mlp_activations;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld1, vld2;
  logic [17:0] rd1, rd2, write_data_mem;
  logic        rw, cen, MLPvld, done;
  logic [8:0]  addr_port1_x, addr_port1_y, addr_port2_x, addr_port2_y;
  logic [18:0] cavier_in = '0;
  logic        cavier_in_vld = 1'b0, current_timestamp_vld = 1'b0;
  logic [15:0] current_timestamp = '0;
  logic [15:0] MLPout1, MLPout3;
  logic [1:0]  MLPout2, MLPout4;
  logic [2:0]  dbg_state;
  logic [93:0] all_outs;

  int checks = 0, errors = 0;
  int beat_cnt = 0, wr_cnt = 0, done_cnt = 0;
  logic [35:0] exp_q[$];
  logic [35:0] addr_q[$];
  logic [35:0] wr_q[$];
  logic [35:0] beat_log[$];
  logic [35:0] wr_last = '0;
  logic [17:0] ovr [int];

  always #5 clk = ~clk;

  create_mlp_activations dut (
    .clk(clk), .rst_n(rst_n),
    .read_data_mem_vld1(vld1), .read_data_mem_vld2(vld2),
    .read_data1_mem(rd1), .read_data2_mem(rd2),
    .write_data_mem(write_data_mem), .rw(rw), .cen(cen),
    .addr_port1_x(addr_port1_x), .addr_port1_y(addr_port1_y),
    .addr_port2_x(addr_port2_x), .addr_port2_y(addr_port2_y),
    .cavier_in(cavier_in), .cavier_in_vld(cavier_in_vld),
    .current_timestamp(current_timestamp), .current_timestamp_vld(current_timestamp_vld),
    .MLPout1(MLPout1), .MLPout2(MLPout2), .MLPout3(MLPout3), .MLPout4(MLPout4),
    .MLPvld(MLPvld), .done(done), .dbg_state(dbg_state)
  );

  assign all_outs = {cen, rw, MLPvld, done, MLPout1, MLPout2, MLPout3, MLPout4, write_data_mem,
                     addr_port1_x, addr_port1_y, addr_port2_x, addr_port2_y};

  // Memory contents: written words override the x+y pattern in the 8x8 corner, 0 elsewhere.
  function automatic logic [17:0] mem_word(input int x, input int y);
    if (ovr.exists(x * 512 + y)) return ovr[x * 512 + y];
    if (x < 8 && y < 8) return 18'(x + y);
    return '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1 <= 1'b0; vld2 <= 1'b0; rd1 <= '0; rd2 <= '0;
    end else begin
      vld1 <= 1'b0; vld2 <= 1'b0;
      if (cen && !rw) begin
        rd1 <= mem_word(addr_port1_x, addr_port1_y);
        rd2 <= mem_word(addr_port2_x, addr_port2_y);
        vld1 <= 1'b1; vld2 <= 1'b1;
      end
      if (cen && rw) ovr[addr_port1_x * 512 + addr_port1_y] = write_data_mem;
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference activation for one stored word.
  function automatic logic [17:0] act(input logic [17:0] w, input int cur, input bit zero);
    int code, delta;
    code  = int'(w[1:0]);
    delta = (cur - int'(w[17:2]) + 65536) % 65536;
    if (zero || !(code == 1 || code == 3) || delta >= 1000) return '0;
    return {16'(1000 - delta), 2'(code)};
  endfunction

  task automatic pixel(input int k, input int ex, input int ey, output bit oob,
                       output int px, output int py);
    px  = ex + k % 7 - 3;
    py  = ey + k / 7 - 3;
    oob = (k >= 49) || px < 0 || py < 0 || px >= 346 || py >= 260;
  endtask

  task automatic push_expect(input int ex, input int ey, input int epol, input int ets);
    bit oob1, oob2, mask;
    int x1, y1, x2, y2;
    logic [17:0] a1, a2;
    mask = 1'b0;
`ifdef MLP_CENTER_MASK_EN
    mask = 1'b1;
`endif
    for (int i = 0; i < 25; i++) begin
      pixel(2 * i, ex, ey, oob1, x1, y1);
      pixel(2 * i + 1, ex, ey, oob2, x2, y2);
      a1 = act(oob1 ? 18'd0 : mem_word(x1, y1), ets, oob1 || (mask && i == 12));
      a2 = act(oob2 ? 18'd0 : mem_word(x2, y2), ets, oob2);
      exp_q.push_back({a1, a2});
      addr_q.push_back({oob1 ? 9'd0 : 9'(x1), oob1 ? 9'd0 : 9'(y1),
                        oob2 ? 9'd0 : 9'(x2), oob2 ? 9'd0 : 9'(y2)});
    end
    wr_q.push_back({9'(ex), 9'(ey), 16'(ets), (epol != 0) ? 2'b01 : 2'b11});
  endtask

  // Monitor: every memory cycle and output beat is popped against the expected queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (MLPvld) begin
        logic [35:0] got;
        got = {MLPout1, MLPout2, MLPout3, MLPout4};
        beat_log.push_back(got);
        beat_cnt++;
        if (exp_q.size() == 0) check("beat_unexpected", got, 36'h0_0000_0000 ^ ~got);
        else check($sformatf("beat%0d", beat_cnt - 1), got, exp_q.pop_front());
      end
      if (cen && !rw) begin
        logic [35:0] ga;
        ga = {addr_port1_x, addr_port1_y, addr_port2_x, addr_port2_y};
        if (addr_q.size() == 0) check("read_unexpected", ga, ~ga);
        else check("read_addr", ga, addr_q.pop_front());
      end
      if (cen && rw) begin
        logic [35:0] gw;
        gw = {addr_port1_x, addr_port1_y, write_data_mem};
        wr_cnt++;
        wr_last = gw;
        if (wr_q.size() == 0) check("write_unexpected", gw, ~gw);
        else check("write", gw, wr_q.pop_front());
      end
      if (done) done_cnt++;
    end
  end

  task automatic send_event(input int x, input int y, input int pol, input int ts, input bit expect_it);
    @(negedge clk);
    cavier_in = {9'(x), 9'(y), 1'(pol)};
    current_timestamp = 16'(ts);
    cavier_in_vld = 1'b1;
    current_timestamp_vld = 1'b1;
    if (expect_it) push_expect(x, y, pol, ts);
    @(negedge clk);
    cavier_in_vld = 1'b0;
    current_timestamp_vld = 1'b0;
  endtask

  task automatic wait_done(input int start);
    int n;
    n = 0;
    while (done_cnt == start && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", (done_cnt != start), 1'b1);
  endtask

  task automatic run_event(input int x, input int y, input int pol, input int ts, input bit glitch);
    int d0, w0;
    beat_log.delete();
    beat_cnt = 0;
    d0 = done_cnt;
    w0 = wr_cnt;
    send_event(x, y, pol, ts, 1'b1);
    if (glitch) begin
      repeat (4) @(negedge clk);
      send_event(6, 6, 0, 999, 1'b0);
    end
    wait_done(d0);
    repeat (3) @(negedge clk);
    check("beat_count", beat_cnt, 25);
    check("write_count", wr_cnt - w0, 1);
    check("done_count", done_cnt - d0, 1);
    check("queues_drained", exp_q.size() + addr_q.size() + wr_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs, '0);
    check("reset_state", dbg_state, 3'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {cen, MLPvld, done}, 3'b000);

    // Main case (4,4) ON at ts=100.
    run_event(4, 4, 1, 100, 1'b0);
    check("t2_beat0", beat_log[0], {16'd0, 2'b00, 16'd900, 2'b11});
    check("t2_beat1_px2", beat_log[1][17:0], {16'd901, 2'b01});
    check("t2_beat24", beat_log[24], 36'd0);
    check("t2_write", wr_last, {9'd4, 9'd4, 18'h00191});

    // Corner event: negative coordinates.
    run_event(0, 0, 0, 50, 1'b0);
    check("t3_beat0", beat_log[0], 36'd0);
    check("t3_beat12", beat_log[12], {18'd0, 16'd950, 2'b01});
    check("t3_write", wr_last, {9'd0, 9'd0, 18'd203});

    // Timestamp wrap, and delta exactly TAU.
    ovr[17 * 512 + 17] = {16'd65500, 2'b01};
    run_event(20, 20, 1, 10, 1'b0);
    check("t4_wrap", beat_log[0][35:18], {16'd954, 2'b01});
    ovr[18 * 512 + 17] = {16'd0, 2'b01};
    run_event(20, 20, 0, 1000, 1'b0);
    check("t4_delta_tau", beat_log[0][17:0], 18'd0);
`ifdef MLP_CENTER_MASK_EN
    check("t4_center", beat_log[12], 36'd0);
`else
    check("t4_center", beat_log[12], {16'd10, 2'b01, 18'd0});
`endif

    // Event pulsed while busy is dropped; the next one is processed.
    run_event(2, 3, 1, 200, 1'b1);
    run_event(6, 6, 0, 300, 1'b0);
    check("t5_write", wr_last, {9'd6, 9'd6, 16'd300, 2'b11});

    // Reset in the middle of READ.
    w0 = wr_cnt;
    send_event(3, 3, 1, 400, 1'b1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_reset_outputs", all_outs, '0);
    check("t6_reset_state", dbg_state, 3'd0);
    exp_q.delete();
    addr_q.delete();
    wr_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("t6_no_writeback", wr_cnt - w0, 0);
    run_event(3, 3, 1, 400, 1'b0);
    check("t6_restart_write", wr_last, {9'd3, 9'd3, 16'd400, 2'b01});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
